adc_pulse_gen: RTL
==================

ADC_PULSE_GEN -- requirements
Module: adc_pulse_gen

Interface
REQ-001 Parameter RISE_SHIFT, 2, rise length is 2^RISE_SHIFT samples.
REQ-002 Parameter DECAY_SHIFT, 4, decay time constant is about 2^DECAY_SHIFT samples.
REQ-003 Parameter FRAC, 8, fractional bits of the internal accumulator.
REQ-004 Parameter END_LEVEL, 1, integer pulse level below which the decay ends.
REQ-005 clk  in  1  single clock; all logic is on the rising edge.
REQ-006 reset  in  1  synchronous, active-low reset.
REQ-007 enable  in  1  allows triggers to be accepted.
REQ-008 trigger  in  1  pulse request, sampled at each rising edge.
REQ-009 amplitude  in  SIZE_ADC_DATA  pulse height in ADC counts, latched on acceptance.
REQ-010 baseline  in  SIZE_ADC_DATA  pedestal added to the pulse, latched on acceptance.
REQ-011 output_data  out  SIZE_ADC_DATA  registered synthetic ADC sample; feeds the shaping filter input_data.
REQ-012 busy  out  1  high while state is not IDLE.
REQ-013 pulse_start  out  1  one-cycle strobe when a trigger is accepted.
REQ-014 trig_lost  out  1  one-cycle strobe when a trigger is rejected because busy is high.
REQ-015 sat  out  1  one-cycle strobe on each cycle in which output_data is clipped.

Function
REQ-016 The FSM SHALL have three states: IDLE, RISE and DECAY.
REQ-017 In IDLE, trigger=1, enable=1 and amplitude!=0 SHALL cause the following:
  - baseline and amplitude are latched;
  - step = (amplitude<<FRAC)>>RISE_SHIFT;
  - acc = step;
  - the rise counter is set to 1;
  - the state goes to RISE;
  - pulse_start is set to 1.
REQ-018 In IDLE, a trigger with amplitude=0 or enable=0 SHALL be ignored, with no strobe.
REQ-019 In IDLE, acc SHALL be 0 and the baseline register SHALL track the baseline input every cycle.
REQ-020 In RISE, acc SHALL increase by step each cycle.
REQ-021 RISE SHALL last 2^RISE_SHIFT cycles.
REQ-022 RISE SHALL then go to DECAY, with acc equal to the latched amplitude<<FRAC truncated to a multiple of step.
REQ-023 In DECAY, each cycle SHALL set acc = acc - (acc>>DECAY_SHIFT), using a logical shift on an unsigned accumulator.
REQ-024 DECAY SHALL go to IDLE, with acc cleared, in the cycle that evaluates (acc>>FRAC) < END_LEVEL.
REQ-025 If DECAY_SHIFT=0, DECAY SHALL last exactly one cycle.
REQ-026 Any trigger while busy=1 SHALL be ignored and SHALL pulse trig_lost for one cycle; the pulse in progress is unaffected.
REQ-027 enable deasserted mid-pulse SHALL NOT abort the pulse; only new acceptance is blocked.
REQ-028 output_data SHALL be registered as sum = baseline_reg + (acc>>FRAC), computed in SIZE_ADC_DATA+1 bits.
REQ-029 If sum exceeds 2^SIZE_ADC_DATA-1, output_data SHALL be set to all ones and sat=1.
REQ-030 Latency: for a trigger accepted at edge N, the first rise sample SHALL appear on output_data after edge N+1; the peak SHALL appear after edge N+2^RISE_SHIFT.
REQ-031 The accumulator width SHALL be SIZE_ADC_DATA+FRAC, which cannot overflow.

Reset
REQ-032 On reset=0 at a clock edge, the following SHALL be cleared:
  - state SHALL go to IDLE;
  - acc, step, counters and latched registers SHALL be 0;
  - output_data SHALL be 0;
  - busy, pulse_start, trig_lost and sat SHALL be 0.
REQ-033 Reset mid-pulse SHALL abort immediately.
REQ-034 A trigger in the first cycle after reset release SHALL be accepted normally.

Structure
REQ-035 SIZE_ADC_DATA SHALL come from package_settings.
REQ-036 Parameter defaults and the state enum typedef SHALL reside in a new package, pulse_gen_parameters.
REQ-037 The saturating adder SHALL be one sub-module, sat_add, which is combinational and parameterised by width.
REQ-038 The FSM, the accumulator and the output register SHALL stay in adc_pulse_gen.

Verification
REQ-039 Every scenario SHALL use SIZE_ADC_DATA=12 and the default parameters.
REQ-040 The bench SHALL cover these directed scenarios:
  - Basic pulse: baseline=100, amplitude=400, one trigger -> output 200, 300, 400, 500; the next decay output is 475 (acc 102400->96000); busy falls when the level drops below 1; pulse_start is seen once.
  - Retrigger: trigger again 3 cycles after acceptance -> trig_lost=1 for one cycle; the waveform is identical to the basic pulse.
  - Saturation: baseline=4000, amplitude=400 -> output 4095 with sat=1 from the first rise sample until the sum is no longer above 4095.
  - Zero amplitude or enable=0: trigger -> busy, pulse_start and trig_lost stay 0; output_data equals the baseline one cycle later.
  - Reset mid-decay: reset=0 for one edge -> output_data=0, busy=0; a trigger right after release restarts a correct pulse.
  - Odd amplitude: amplitude=7 -> step=448; peak acc=1792; peak output=baseline+7; there is no overflow.

Source files
------------

// File: rtl/adc_pulse_gen_pkg.sv
// Shared settings and pulse generator defaults.
// package_settings carries the project-wide ADC data width.
package package_settings;
   localparam int unsigned SIZE_ADC_DATA = 12;
endpackage

package pulse_gen_parameters;
   localparam int unsigned RISE_SHIFT_DEF  = 2;
   localparam int unsigned DECAY_SHIFT_DEF = 4;
   localparam int unsigned FRAC_DEF        = 8;
   localparam int unsigned END_LEVEL_DEF   = 1;

   typedef enum logic [1:0] {
      IDLE,
      RISE,
      DECAY
   } pg_state_e;
endpackage

// File: rtl/adc_pulse_gen_if.sv
// Trigger/amplitude request and synthetic ADC sample bundle for adc_pulse_gen.
interface adc_pulse_gen_if;
   import package_settings::*;

   logic                     enable;
   logic                     trigger;
   logic [SIZE_ADC_DATA-1:0] amplitude;
   logic [SIZE_ADC_DATA-1:0] baseline;
   logic [SIZE_ADC_DATA-1:0] output_data;
   logic                     busy;
   logic                     pulse_start;
   logic                     trig_lost;
   logic                     sat;

   modport master (
      output enable, trigger, amplitude, baseline,
      input  output_data, busy, pulse_start, trig_lost, sat
   );

   modport slave (
      input  enable, trigger, amplitude, baseline,
      output output_data, busy, pulse_start, trig_lost, sat
   );
endinterface

// File: rtl/adc_pulse_gen_sat_add.sv
// Unsigned adder that clips to all ones on carry-out.
module sat_add #(
   parameter int unsigned WIDTH = 12
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] sum,
   output logic             sat
);
   logic [WIDTH:0] full;

   always_comb begin
      full = {1'b0, a} + {1'b0, b};
      sat  = full[WIDTH];
      sum  = full[WIDTH] ? '1 : full[WIDTH-1:0];
   end
endmodule

// File: rtl/adc_pulse_gen.sv
// Synthetic ADC pulse: linear rise over 2^RISE_SHIFT samples, then exponential
// decay on a fixed-point accumulator, added to a latched pedestal.
module adc_pulse_gen
   import package_settings::*;
   import pulse_gen_parameters::*;
#(
   parameter int unsigned RISE_SHIFT  = RISE_SHIFT_DEF,
   parameter int unsigned DECAY_SHIFT = DECAY_SHIFT_DEF,
   parameter int unsigned FRAC        = FRAC_DEF,
   parameter int unsigned END_LEVEL   = END_LEVEL_DEF
) (
   input  logic            clk,
   input  logic            reset,
   adc_pulse_gen_if.slave  pg
);
   localparam int unsigned ACC_W    = SIZE_ADC_DATA + FRAC;
   localparam int unsigned CNT_W    = RISE_SHIFT + 1;
   localparam int unsigned RISE_LEN = 2 ** RISE_SHIFT;

   pg_state_e                state_q, state_d;
   logic [ACC_W-1:0]         acc_q, acc_d, step_q, step_d;
   logic [ACC_W-1:0]         acc_dec, step_new;
   logic [CNT_W-1:0]         cnt_q, cnt_d;
   logic [SIZE_ADC_DATA-1:0] base_q, base_d, out_q, out_d, sum;
   logic                     busy_q, busy_d, start_q, start_d;
   logic                     lost_q, lost_d, sat_q, sat_d, sum_sat;
   logic                     accept;

   sat_add #(.WIDTH(SIZE_ADC_DATA)) u_sat_add (
      .a   (base_q),
      .b   (acc_q[ACC_W-1:FRAC]),
      .sum (sum),
      .sat (sum_sat)
   );

   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      step_d   = step_q;
      cnt_d    = cnt_q;
      base_d   = base_q;
      acc_dec  = acc_q - (acc_q >> DECAY_SHIFT);
      step_new = (ACC_W'(pg.amplitude) << FRAC) >> RISE_SHIFT;
      accept   = (state_q == IDLE) && pg.trigger && pg.enable && (pg.amplitude != '0);
      start_d  = accept;
      lost_d   = pg.trigger && (state_q != IDLE);
      out_d    = sum;
      sat_d    = sum_sat;

      case (state_q)
         IDLE: begin
            acc_d  = '0;
            cnt_d  = '0;
            base_d = pg.baseline;
            if (accept) begin
               step_d  = step_new;
               acc_d   = step_new;
               cnt_d   = CNT_W'(1);
               state_d = (RISE_LEN == 1) ? DECAY : RISE;
            end
         end
         RISE: begin
            acc_d = acc_q + step_q;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(RISE_LEN - 1)) state_d = DECAY;
         end
         DECAY: begin
            // End test uses the decayed value, so DECAY_SHIFT=0 leaves after one cycle.
            if ((acc_dec >> FRAC) < ACC_W'(END_LEVEL)) begin
               state_d = IDLE;
               acc_d   = '0;
            end else begin
               acc_d   = acc_dec;
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
         acc_q   <= '0;
         step_q  <= '0;
         cnt_q   <= '0;
         base_q  <= '0;
         out_q   <= '0;
         busy_q  <= 1'b0;
         start_q <= 1'b0;
         lost_q  <= 1'b0;
         sat_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         step_q  <= step_d;
         cnt_q   <= cnt_d;
         base_q  <= base_d;
         out_q   <= out_d;
         busy_q  <= busy_d;
         start_q <= start_d;
         lost_q  <= lost_d;
         sat_q   <= sat_d;
      end
   end

   assign pg.output_data = out_q;
   assign pg.busy        = busy_q;
   assign pg.pulse_start = start_q;
   assign pg.trig_lost   = lost_q;
   assign pg.sat         = sat_q;
endmodule
